// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: ALU control codes, RV32I opcodes,
// operand-select encodings and the registered issue payload.
package alu_pkg;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_SLT  = 4'd9;
    localparam logic [3:0] ALU_SLTU = 4'd10;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        A_SEL_RS1  = 2'd0,
        A_SEL_PC   = 2'd1,
        A_SEL_ZERO = 2'd2
    } a_sel_e;

    typedef enum logic [1:0] {
        B_SEL_RS2  = 2'd0,
        B_SEL_IMM  = 2'd1,
        B_SEL_FOUR = 2'd2,
        B_SEL_ZERO = 2'd3
    } b_sel_e;

    typedef struct packed {
        logic [XLEN-1:0]  a;
        logic [XLEN-1:0]  b;
        logic [3:0]       ctrl;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } issue_t;

    // Register/immediate integer ops; allow_sub is clear for OP-IMM, which has no SUBI.
    function automatic logic [3:0] int_alu_ctrl(input logic [2:0] funct3,
                                                input logic       funct7_5,
                                                input logic       allow_sub);
        logic [3:0] ctrl;
        ctrl = ALU_ADD;
        case (funct3)
            3'b000:  ctrl = (allow_sub && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b001:  ctrl = ALU_SLL;
            3'b010:  ctrl = ALU_SLT;
            3'b011:  ctrl = ALU_SLTU;
            3'b100:  ctrl = ALU_XOR;
            3'b101:  ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
            3'b110:  ctrl = ALU_OR;
            3'b111:  ctrl = ALU_AND;
            default: ctrl = ALU_ADD;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I decode into ALU control code, operand selects and illegal flag.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_5,
    output logic [3:0] o_ctrl,
    output a_sel_e     o_a_sel,
    output b_sel_e     o_b_sel,
    output logic       o_illegal
);

    // Anything undecodable leaves the zero operands and ADD code set by the defaults.
    always_comb begin
        o_ctrl    = ALU_ADD;
        o_a_sel   = A_SEL_ZERO;
        o_b_sel   = B_SEL_ZERO;
        o_illegal = 1'b0;
        case (i_opcode)
            OPC_OP: begin
                o_a_sel = A_SEL_RS1;
                o_b_sel = B_SEL_RS2;
                o_ctrl  = int_alu_ctrl(i_funct3, i_funct7_5, 1'b1);
            end
            OPC_OPIMM: begin
                o_a_sel = A_SEL_RS1;
                o_b_sel = B_SEL_IMM;
                o_ctrl  = int_alu_ctrl(i_funct3, i_funct7_5, 1'b0);
            end
            OPC_LUI: begin
                o_a_sel = A_SEL_ZERO;
                o_b_sel = B_SEL_IMM;
            end
            OPC_AUIPC: begin
                o_a_sel = A_SEL_PC;
                o_b_sel = B_SEL_IMM;
            end
            OPC_LOAD, OPC_STORE, OPC_JALR: begin
                o_a_sel = A_SEL_RS1;
                o_b_sel = B_SEL_IMM;
            end
            OPC_JAL: begin
                o_a_sel = A_SEL_PC;
                o_b_sel = B_SEL_FOUR;
            end
            OPC_BRANCH: begin
                case (i_funct3[2:1])
                    2'b00: begin
                        o_a_sel = A_SEL_RS1;
                        o_b_sel = B_SEL_RS2;
                        o_ctrl  = ALU_SUB;
                    end
                    2'b10: begin
                        o_a_sel = A_SEL_RS1;
                        o_b_sel = B_SEL_RS2;
                        o_ctrl  = ALU_SLT;
                    end
                    2'b11: begin
                        o_a_sel = A_SEL_RS1;
                        o_b_sel = B_SEL_RS2;
                        o_ctrl  = ALU_SLTU;
                    end
                    default: o_illegal = 1'b1;
                endcase
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes and muxes ALU operands, then holds them in a
// main/skid register pair so in_ready depends only on registered state.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int XLEN  = alu_pkg::XLEN,
    parameter int TAG_W = alu_pkg::TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [6:0]       in_opcode,
    input  logic [2:0]       in_funct3,
    input  logic             in_funct7_5,
    input  logic [XLEN-1:0]  in_rs1_val,
    input  logic [XLEN-1:0]  in_rs2_val,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_a,
    output logic [XLEN-1:0]  out_b,
    output logic [3:0]       out_alu_control,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    logic [3:0] w_ctrl;
    a_sel_e     w_a_sel;
    b_sel_e     w_b_sel;
    logic       w_illegal;
    logic       w_accept;
    issue_t     w_dec;
    issue_t     r_m;
    issue_t     r_s;
    logic       r_m_valid;
    logic       r_s_valid;

    alu_op_decode u_decode (
        .i_opcode   (in_opcode),
        .i_funct3   (in_funct3),
        .i_funct7_5 (in_funct7_5),
        .o_ctrl     (w_ctrl),
        .o_a_sel    (w_a_sel),
        .o_b_sel    (w_b_sel),
        .o_illegal  (w_illegal)
    );

    // A skid slot is only ever occupied while M is full, so an empty skid means space.
    assign w_accept = in_valid & ~r_s_valid;

    // Operand mux and payload assembly for the op currently presented.
    always_comb begin
        w_dec = '0;
        case (w_a_sel)
            A_SEL_RS1: w_dec.a = in_rs1_val;
            A_SEL_PC:  w_dec.a = in_pc;
            default:   w_dec.a = '0;
        endcase
        case (w_b_sel)
            B_SEL_RS2:  w_dec.b = in_rs2_val;
            B_SEL_IMM:  w_dec.b = in_imm;
            B_SEL_FOUR: w_dec.b = {{(XLEN-3){1'b0}}, 3'b100};
            default:    w_dec.b = '0;
        endcase
        w_dec.ctrl    = w_ctrl;
        w_dec.illegal = w_illegal;
        w_dec.tag     = in_tag;
    end

    // Main/skid registers; flush drops valids but keeps payloads, reset also clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_valid <= 1'b0;
            r_s_valid <= 1'b0;
            r_m       <= '0;
            r_s       <= '0;
        end else if (flush) begin
            r_m_valid <= 1'b0;
            r_s_valid <= 1'b0;
        end else if (!r_m_valid || out_ready) begin
            if (r_s_valid) begin
                r_m       <= r_s;
                r_m_valid <= 1'b1;
                r_s_valid <= 1'b0;
            end else if (w_accept) begin
                r_m       <= w_dec;
                r_m_valid <= 1'b1;
            end else begin
                r_m_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_s       <= w_dec;
            r_s_valid <= 1'b1;
        end else begin
            r_s_valid <= r_s_valid;
        end
    end

    assign in_ready        = ~r_s_valid;
    assign out_valid       = r_m_valid;
    assign out_a           = r_m.a;
    assign out_b           = r_m.b;
    assign out_alu_control = r_m.ctrl;
    assign out_illegal     = r_m.illegal;
    assign out_tag         = r_m.tag;

endmodule
